// File: rtl/store_buffer.sv
// Posted-write queue in front of data_memory: stores drain FIFO one per cycle,
// and loads see the youngest queued store to the same word address.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     drain_hold,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_fwd,
  output logic                     WE_dmem,
  output logic [ADDR_W-1:0]        dmem_addr,
  output logic [DATA_W-1:0]        dmem_wdata,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic push;
  logic drain;

  // Handshake: a store is taken when st_valid & st_ready; st_ready is derived
  // from the registered count only, so a full queue refuses even while draining.
  assign st_ready   = (count != CNT_W'(DEPTH));
  assign sb_empty   = (count == '0);
  assign sb_count   = count;
  assign push       = st_valid & st_ready;
  assign drain      = WE_dmem;

  assign WE_dmem    = !sb_empty & !drain_hold;
  assign dmem_addr  = addr_q[rd_ptr];
  assign dmem_wdata = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
    end
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  logic [PTR_W-1:0] idx;
  always_comb begin
    ld_fwd  = 1'b0;
    ld_data = mem_rdata;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
        ld_fwd  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand-written
// sequences for pointer wrap with simultaneous push/drain and mid-drain reset.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        drain_hold;
  logic [15:0] ld_addr;
  logic [15:0] mem_rdata;
  logic [15:0] ld_data;
  logic        ld_fwd;
  logic        WE_dmem;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        sb_empty;
  logic [2:0]  sb_count;

  store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .drain_hold (drain_hold),
    .ld_addr    (ld_addr),
    .mem_rdata  (mem_rdata),
    .ld_data    (ld_data),
    .ld_fwd     (ld_fwd),
    .WE_dmem    (WE_dmem),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural data_memory: async read, write on rising edge
  logic [15:0] mem [0:255];
  int          wr_count;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    wr_count = 0;
  end
  assign mem_rdata = mem[ld_addr[7:0]];
  always @(posedge clk) begin
    if (WE_dmem) begin
      mem[dmem_addr[7:0]] = dmem_wdata;
      wr_count++;
    end
  end

  int tests_run;
  int tests_failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic hold, input logic [15:0] la);
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    drain_hold = hold;
    ld_addr    = la;
  endtask

  typedef struct {
    logic        sv;
    logic [15:0] sa;
    logic [15:0] sd;
    logic        hold;
    logic [15:0] la;
    logic        ewe;
    logic [15:0] ea;
    logic [15:0] ed;
    logic        efwd;
    logic [15:0] eld;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                              input logic hold, input logic [15:0] la, input logic ewe,
                              input logic [15:0] ea, input logic [15:0] ed, input logic efwd,
                              input logic [15:0] eld, input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.hold = hold; v.la = la;
    v.ewe = ewe; v.ea = ea; v.ed = ed; v.efwd = efwd; v.eld = eld;
    v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  // scoreboard for the wrap sequence
  logic [31:0] exp_q[$];
  logic [15:0] ref_mem [0:255];

  initial begin
    int wc;
    logic [31:0] e;
    logic [15:0] a;
    logic [15:0] d;
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;

    // reset
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    #2;
    chk("rst_we", 32'(WE_dmem), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_fwd", 32'(ld_fwd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_writes", 32'(wr_count), 32'd0);

    // single store, forwarding, fill
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h10, 0, 16'h0,  16'h0,    0, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 16'h10, 16'hBEEF, 0, 16'h10, 0, 16'h0,  16'h0,    0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h10, 1, 16'h10, 16'hBEEF, 1, 16'hBEEF, 1, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h10, 0, 16'h0,  16'h0,    0, 16'hBEEF, 0, 1));
    vecs.push_back(mk(1, 16'h20, 16'h1111, 1, 16'h20, 0, 16'h0,  16'h0,    0, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 16'h20, 16'h2222, 1, 16'h20, 0, 16'h0,  16'h0,    1, 16'h1111, 1, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 1, 16'h20, 0, 16'h0,  16'h0,    1, 16'h2222, 2, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 1, 16'h21, 0, 16'h0,  16'h0,    0, 16'h0000, 2, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h20, 1, 16'h20, 16'h1111, 1, 16'h2222, 2, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h20, 1, 16'h20, 16'h2222, 1, 16'h2222, 1, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h20, 0, 16'h0,  16'h0,    0, 16'h2222, 0, 1));
    vecs.push_back(mk(1, 16'h30, 16'hA000, 1, 16'h30, 0, 16'h0,  16'h0,    0, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 16'h31, 16'hA001, 1, 16'h30, 0, 16'h0,  16'h0,    1, 16'hA000, 1, 1));
    vecs.push_back(mk(1, 16'h32, 16'hA002, 1, 16'h30, 0, 16'h0,  16'h0,    1, 16'hA000, 2, 1));
    vecs.push_back(mk(1, 16'h33, 16'hA003, 1, 16'h30, 0, 16'h0,  16'h0,    1, 16'hA000, 3, 1));
    vecs.push_back(mk(1, 16'h40, 16'hDEAD, 1, 16'h40, 0, 16'h0,  16'h0,    0, 16'h0000, 4, 0));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 1, 16'h40, 0, 16'h0,  16'h0,    0, 16'h0000, 4, 0));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h33, 1, 16'h30, 16'hA000, 1, 16'hA003, 4, 0));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h33, 1, 16'h31, 16'hA001, 1, 16'hA003, 3, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h33, 1, 16'h32, 16'hA002, 1, 16'hA003, 2, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h33, 1, 16'h33, 16'hA003, 1, 16'hA003, 1, 1));
    vecs.push_back(mk(0, 16'h00, 16'h0000, 0, 16'h40, 0, 16'h0,  16'h0,    0, 16'h0000, 0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].hold, vecs[i].la);
      #1;
      chk($sformatf("v%0d_we", i), 32'(WE_dmem), 32'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        chk($sformatf("v%0d_addr", i), 32'(dmem_addr), 32'(vecs[i].ea));
        chk($sformatf("v%0d_wdata", i), 32'(dmem_wdata), 32'(vecs[i].ed));
      end
      chk($sformatf("v%0d_fwd", i), 32'(ld_fwd), 32'(vecs[i].efwd));
      chk($sformatf("v%0d_ld", i), 32'(ld_data), 32'(vecs[i].eld));
      chk($sformatf("v%0d_cnt", i), 32'(sb_count), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_rdy", i), 32'(st_ready), 32'(vecs[i].erdy));
      chk($sformatf("v%0d_empty", i), 32'(sb_empty), 32'(vecs[i].ecnt == 3'd0));
    end
    chk("dropped_store_unwritten", 32'(mem[8'h40]), 32'h0000);
    chk("mem_10", 32'(mem[8'h10]), 32'hBEEF);
    chk("mem_20", 32'(mem[8'h20]), 32'h2222);

    // wrap: two entries queued, then push+drain together for 10 cycles
    for (int i = 0; i < 12; i++) begin
      a = 16'h50 + 16'(i % 5);
      d = 16'h5000 + 16'(i * 16'h0111);
      @(negedge clk);
      drive(1'b1, a, d, (i < 2), 16'h0);
      #1;
      if (i >= 2) begin
        chk($sformatf("wrap%0d_cnt", i), 32'(sb_count), 32'd2);
        chk($sformatf("wrap%0d_we", i), 32'(WE_dmem), 32'd1);
        chk($sformatf("wrap%0d_rdy", i), 32'(st_ready), 32'd1);
        e = exp_q.pop_front();
        chk($sformatf("wrap%0d_head", i), {dmem_addr, dmem_wdata}, e);
      end
      exp_q.push_back({a, d});
      ref_mem[a[7:0]] = d;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      #1;
      chk($sformatf("wrap_tail%0d_we", i), 32'(WE_dmem), 32'd1);
      e = exp_q.pop_front();
      chk($sformatf("wrap_tail%0d_head", i), {dmem_addr, dmem_wdata}, e);
    end
    @(negedge clk);
    #1;
    chk("wrap_empty", 32'(sb_empty), 32'd1);
    for (int i = 8'h50; i < 8'h55; i++)
      chk($sformatf("wrap_mem_%0h", i), 32'(mem[i]), 32'(ref_mem[i]));

    // reset while draining three queued stores
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h60 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h60);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h60);
    #1;
    chk("mid_cnt", 32'(sb_count), 32'd3);
    chk("mid_fwd", 32'(ld_fwd), 32'd1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h60);
    #1;
    chk("mid_we_before", 32'(WE_dmem), 32'd1);
    wc = wr_count;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_we_after", 32'(WE_dmem), 32'd0);
    chk("mid_empty", 32'(sb_empty), 32'd1);
    chk("mid_cnt0", 32'(sb_count), 32'd0);
    chk("mid_rdy", 32'(st_ready), 32'd1);
    chk("mid_fwd0", 32'(ld_fwd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_writes", 32'(wr_count), 32'(wc));
    chk("mid_mem60", 32'(mem[8'h60]), 32'h0000);
    chk("mid_empty_after", 32'(sb_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
